// File: rtl/song_bank_memory_if.sv
// Control and data bundle between a song-bank client (player, learning or game
// datapath) and the multi-slot note memory.
`timescale 1ns/1ps

interface song_bank_memory_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_W      = 6,
   parameter int SEL_W       = 2,
   parameter int STATE_WIDTH = 2
);

   logic [STATE_WIDTH-1:0] current_state;
   logic [SEL_W-1:0]       song_sel;
   logic                   write_en;
   logic                   clear_en;
   logic [DATA_WIDTH-1:0]  data_in;
   logic                   read_en;
   logic                   read_rst;
   logic                   loop_en;
   logic [DATA_WIDTH-1:0]  data_out;
   logic                   output_ready;
   logic                   song_end;
   logic                   full;
   logic [ADDR_W:0]        duration;

   // The client drives mode, slot selection and record/playback requests.
   modport master (
      output current_state,
      output song_sel,
      output write_en,
      output clear_en,
      output data_in,
      output read_en,
      output read_rst,
      output loop_en,
      input  data_out,
      input  output_ready,
      input  song_end,
      input  full,
      input  duration
   );

   modport slave (
      input  current_state,
      input  song_sel,
      input  write_en,
      input  clear_en,
      input  data_in,
      input  read_en,
      input  read_rst,
      input  loop_en,
      output data_out,
      output output_ready,
      output song_end,
      output full,
      output duration
   );

endinterface

// File: rtl/song_bank_memory.sv
// Multi-slot note memory: records into the selected slot in free-play mode and
// plays it back with one-cycle read latency, optional looping and end strobe.
`timescale 1ns/1ps

module song_bank_memory #(
   parameter int                     DATA_WIDTH  = 8,
   parameter int                     DEPTH       = 64,
   parameter int                     ADDR_W      = 6,
   parameter int                     NUM_SONGS   = 4,
   parameter int                     SEL_W       = 2,
   parameter int                     STATE_WIDTH = 2,
   parameter logic [STATE_WIDTH-1:0] ST_AUTOPLAY = 2'd0,
   parameter logic [STATE_WIDTH-1:0] ST_LEARNING = 2'd1,
   parameter logic [STATE_WIDTH-1:0] ST_GAME     = 2'd2,
   parameter logic [STATE_WIDTH-1:0] ST_FREE     = 2'd3
) (
   input  logic             clk,
   input  logic             rst_n,
   song_bank_memory_if.slave bus
);

   localparam int LEN_W     = ADDR_W + 1;
   localparam int MEM_AW    = SEL_W + ADDR_W;
   localparam int MEM_WORDS = NUM_SONGS * DEPTH;
   localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0] LEN_ZERO = '0;
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
   logic [LEN_W-1:0]      r_len [NUM_SONGS];
   logic [LEN_W-1:0]      r_rd_ptr;
   logic [SEL_W-1:0]      r_sel_q;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_output_ready;
   logic                  r_song_end;

   logic                  w_play;
   logic                  w_free;
   logic [LEN_W-1:0]      w_len;
   logic                  w_sel_changed;
   logic                  w_rewind;
   logic                  w_issue;
   logic [LEN_W-1:0]      w_ptr_inc;
   logic                  w_last;
   logic                  w_do_clear;
   logic                  w_do_write;
   logic [MEM_AW-1:0]     w_wr_addr;
   logic [MEM_AW-1:0]     w_rd_addr;

   assign w_play = (bus.current_state == ST_AUTOPLAY) ||
                   (bus.current_state == ST_LEARNING) ||
                   (bus.current_state == ST_GAME);
   assign w_free = (bus.current_state == ST_FREE);

   assign w_len         = r_len[bus.song_sel];
   assign w_sel_changed = (bus.song_sel != r_sel_q);

   // A slot switch is treated like a rewind, so the stale pointer of the old
   // slot is never used to address the newly selected one.
   assign w_rewind  = bus.read_rst || w_sel_changed;
   assign w_issue   = w_play && bus.read_en && !w_rewind && (r_rd_ptr < w_len);
   assign w_ptr_inc = r_rd_ptr + LEN_ONE;
   assign w_last    = (w_ptr_inc == w_len);

   assign w_do_clear = w_free && bus.clear_en;
   assign w_do_write = w_free && bus.write_en && !bus.clear_en && (w_len < LEN_FULL);

   assign w_wr_addr = {bus.song_sel, w_len[ADDR_W-1:0]};
   assign w_rd_addr = {bus.song_sel, r_rd_ptr[ADDR_W-1:0]};

   // Note storage is deliberately left out of reset; only lengths define content.
   always_ff @(posedge clk) begin
      if (w_do_write) begin
         r_mem[w_wr_addr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SONGS; i++) begin
            r_len[i] <= LEN_ZERO;
         end
      end else begin
         for (int i = 0; i < NUM_SONGS; i++) begin
            if (SEL_W'(i) == bus.song_sel) begin
               if (w_do_clear) begin
                  r_len[i] <= LEN_ZERO;
               end else if (w_do_write) begin
                  r_len[i] <= r_len[i] + LEN_ONE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_q <= '0;
      end else begin
         r_sel_q <= bus.song_sel;
      end
   end

   // Playback pointer: parks at the slot length when a non-looping song ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= LEN_ZERO;
      end else if (!w_play || w_rewind) begin
         r_rd_ptr <= LEN_ZERO;
      end else if (w_issue) begin
         if (w_last) begin
            r_rd_ptr <= bus.loop_en ? LEN_ZERO : w_len;
         end else begin
            r_rd_ptr <= w_ptr_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out     <= '0;
         r_output_ready <= 1'b0;
         r_song_end     <= 1'b0;
      end else if (!w_play) begin
         r_data_out     <= '0;
         r_output_ready <= 1'b0;
         r_song_end     <= 1'b0;
      end else begin
         r_output_ready <= w_issue;
         r_song_end     <= w_issue && w_last;
         if (w_issue) begin
            r_data_out <= r_mem[w_rd_addr];
         end
      end
   end

   assign bus.data_out     = r_data_out;
   assign bus.output_ready = r_output_ready;
   assign bus.song_end     = r_song_end;
   assign bus.full         = (w_len == LEN_FULL);
   assign bus.duration     = w_len;

endmodule
